// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: instruction-memory read port, redirect request and decode handshake.
// "master" is the fetch unit; "slave" is the memory/decode environment around it.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              o_imem_en;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] i_imem_data;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_valid;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_pc;
  logic              i_ready;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output o_imem_en, o_imem_addr, o_valid, o_instr, o_pc, o_count,
    input  i_imem_data, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_en, o_imem_addr, o_valid, o_instr, o_pc, o_count,
    output i_imem_data, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential-PC prefetcher for a 1-cycle-latency instruction memory, buffering {pc, instr}
// in a DEPTH-entry first-word-fall-through queue; redirect flushes the queue and in-flight read.
module fetch_prefetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic              kill;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            mem [DEPTH];

  logic [CNT_W:0] committed;
  logic           issue;
  logic           push;
  logic           pop;
  entry_t         head;

  // Slots already promised to an outstanding read count as occupied; a same-cycle pop is not credited.
  assign committed = {1'b0, count} + (CNT_W+1)'(inflight);
  assign issue     = !i_rst && !bus.i_redirect && (committed < (CNT_W+1)'(DEPTH));
  assign push      = inflight && !kill;
  assign pop       = bus.o_valid && bus.i_ready;
  assign head      = mem[rd_ptr];

  assign bus.o_imem_en   = issue;
  assign bus.o_imem_addr = fpc;
  assign bus.o_valid     = (count != '0);
  assign bus.o_instr     = head.instr;
  assign bus.o_pc        = head.pc;
  assign bus.o_count     = count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fpc      <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.i_redirect) begin
      // Flush wins over any push/pop this cycle; the last redirect seen sets the target.
      fpc      <= bus.i_redirect_pc;
      inflight <= 1'b0;
      kill     <= inflight;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fpc    <= fpc + ADDR_W'(PC_STEP);
        req_pc <= fpc;
      end
      inflight <= issue;
      kill     <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; count/pointers alone define which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push && !bus.i_redirect) mem[wr_ptr] <= '{pc: req_pc, instr: bus.i_imem_data};
  end

  a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst) count <= CNT_W'(DEPTH));
  a_no_push_full : assert property (@(posedge i_clk) disable iff (i_rst)
                                    !(push && count == CNT_W'(DEPTH)));
endmodule
